cacc_csb_reg_master: RTL
========================

Name: cacc_csb_reg_master

Overview:
- CSB-side initiator for the CACC dual register group.
- Accepts one CSB request packet at a time and decodes address/type.
- Drives the register-file access port (reg_offset / reg_wr_en / reg_wr_data) for one cycle and samples reg_rd_data combinationally in that cycle.
- Returns a read-data or non-posted write-ack response packet; sits between the CSB fabric and the CACC register file.

Parameters:
- BLK_ADDR_HI, 12'h009, value of CSB word address bits [21:10] that selects the CACC block.

Ports:
- nvdla_core_clk  input  1  core clock
- nvdla_core_rstn  input  1  asynchronous, active-low reset
- csb2cacc_req_pvld  input  1  request valid
- csb2cacc_req_prdy  output  1  request ready
- csb2cacc_req_pd  input  63  [21:0] word addr, [53:22] wdat, [54] write, [55] nposted, [56] srcpriv, [60:57] wrbe, [62:61] level
- cacc2csb_resp_valid  output  1  response valid, one-cycle pulse, no backpressure
- cacc2csb_resp_pd  output  34  [31:0] rdata, [32] error, [33] type (0 = read data, 1 = write ack)
- reg_offset  output  12  byte offset to register file
- reg_wr_en  output  1  write strobe to register file
- reg_wr_data  output  32  write data to register file
- reg_rd_data  input  32  combinational read data from register file

Behaviour:
- Reset: asynchronous, active-low (nvdla_core_rstn); clock nvdla_core_clk.
- Reset values: state = IDLE, req_prdy = 1, resp_valid = 0, resp_pd = 0, reg_wr_en = 0, reg_offset = 0, reg_wr_data = 0.
- FSM IDLE: prdy = 1. On pvld & prdy, capture pd into req_q.
  - Hit when addr[21:10] == BLK_ADDR_HI.
  - Go to ACCESS.
- FSM ACCESS (1 cycle): prdy = 0; reg_offset = {addr[9:0], 2'b00}.
  - Write hit: reg_wr_en = 1, reg_wr_data = wdat.
  - Read hit: reg_rd_data is sampled into rdata_q at the clock edge.
  - Go to RESP.
- FSM RESP (1 cycle): prdy = 0.
  - Read: resp_valid = 1, type = 0, rdata = rdata_q (0 if miss), error = 0 unless the optional feature flags it.
  - Non-posted write: resp_valid = 1, type = 1, rdata = 0, error as above.
  - Posted write: no response.
  - Go to IDLE.
- Throughput: request-accept to resp_valid = 2 cycles; one request per 3 cycles.
- Outside ACCESS, reg_wr_en is 0 and reg_offset/reg_wr_data are held at their last driven values (registered outputs).
- Miss (wrong block): no reg_wr_en. Read returns 0. Non-posted write is still acked.
- wrbe ignored: always full 32-bit writes. srcpriv and level ignored.
- pvld while prdy = 0: request held by the upstream, accepted on the next IDLE cycle. No request is dropped or duplicated.
- Reset asserted mid-operation: state returns to IDLE immediately, pending response discarded, reg_wr_en deasserted asynchronously.
- A write to offset 0x008 (op_enable) flows through like any other write; triggering is the register file's job.

Optional Feature:
- Macro: CACC_CSB_ADDR_ERR_EN.
- Defined:
  - A hit whose byte offset is outside {0x008..0x034, 4-aligned} is unmapped.
  - Unmapped write: reg_wr_en is suppressed.
  - Unmapped read or non-posted write: response sets error = 1, rdata = 0.
  - Miss-block accesses also set error = 1.
- Undefined: error is always 0 and all in-block offsets are forwarded.

Decomposition:
- Shared package nvdla_cacc_csb_pkg holds:
  - pd field bit positions;
  - response type encodings RESP_READ = 1'b0, RESP_WRACK = 1'b1;
  - FSM state enum {IDLE, ACCESS, RESP};
  - mapped-offset range constants 12'h008 and 12'h034.
- Sub-module cacc_csb_req_decode: combinational pd field unpack, hit/unmapped detection and offset generation.
- The FSM stays in the top level.

Test Plan:
- Write req addr = 0x2407, wdat = 0x0000_1001, nposted = 1 -> ACCESS cycle shows reg_offset = 0x01c and reg_wr_en = 1 for exactly one cycle; 2 cycles after accept, resp_pd = {1'b1, 1'b0, 32'h0}.
- Read req addr = 0x2404 with reg_rd_data = 0x0001_0001 -> resp_valid pulse, resp_pd = {1'b0, 1'b0, 32'h0001_0001}.
- Posted write addr = 0x240d, wdat = 0xDEAD_BEEF -> reg_wr_en for one cycle with reg_offset = 0x034, no resp_valid within 5 cycles.
- Back-to-back pvld held high for 3 reads -> prdy low during ACCESS/RESP, exactly 3 responses at 3-cycle spacing, in order.
- Reset pulse during ACCESS of a non-posted write -> no resp_valid, all outputs at reset values, next request handled normally.
- With CACC_CSB_ADDR_ERR_EN: read addr = 0x2410 (offset 0x040) -> rdata = 0, error = 1, no reg_wr_en. Without the macro: error = 0.

Source files
------------

// File: rtl/nvdla_cacc_csb_pkg.sv
// -----------------------------------------------------------------------------
// nvdla_cacc_csb_pkg
// Shared definitions for the CACC CSB register master. It holds:
//   - CSB request packet field positions;
//   - response packet field positions and response type encodings;
//   - the register-master FSM state enum;
//   - the mapped byte-offset window used when address-error checking is built in
//     (macro CACC_CSB_ADDR_ERR_EN).
// -----------------------------------------------------------------------------
package nvdla_cacc_csb_pkg;

   // Request packet (csb2cacc_req_pd) layout
   localparam int PD_W        = 63;
   localparam int ADDR_LSB    = 0;
   localparam int ADDR_MSB    = 21;
   localparam int WDAT_LSB    = 22;
   localparam int WDAT_MSB    = 53;
   localparam int WRITE_BIT   = 54;
   localparam int NPOSTED_BIT = 55;
   localparam int IGN_LSB     = 56;  // srcpriv, wrbe, level: not used by this block
   localparam int IGN_MSB     = 62;

   // Response packet (cacc2csb_resp_pd) layout
   localparam int RESP_W        = 34;
   localparam int RESP_ERR_BIT  = 32;
   localparam int RESP_TYPE_BIT = 33;

   localparam logic RESP_READ  = 1'b0;
   localparam logic RESP_WRACK = 1'b1;

   // Register offsets that exist in the CACC register group
   localparam logic [11:0] MAP_LO = 12'h008;
   localparam logic [11:0] MAP_HI = 12'h034;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_e;

   // Per-request information retained between accept and response
   typedef struct packed {
      logic is_write;
      logic nposted;
      logic fwd;      // access reaches the register file
      logic err;      // response error flag
   } req_info_t;

   function automatic logic [RESP_W-1:0] pack_resp(input logic        typ,
                                                   input logic        err,
                                                   input logic [31:0] rdata);
      return {typ, err, rdata};
   endfunction

endpackage

// File: rtl/cacc_csb_req_decode.sv
// -----------------------------------------------------------------------------
// cacc_csb_req_decode
// Combinational unpack of a CSB request packet: block hit detection, register
// byte-offset generation and forwarding/error classification.
// Build option CACC_CSB_ADDR_ERR_EN: in-block offsets outside the mapped
// window are not forwarded and are flagged as errors, as are other-block
// accesses. Without it, every in-block offset is forwarded and error is 0.
//
// Ports:
//   req_pd_i    request packet
//   is_write_o  request is a write
//   nposted_o   write expects an acknowledge
//   hit_o       word address selects this block
//   fwd_o       access is forwarded to the register file
//   err_o       response error flag
//   offset_o    register byte offset
//   wdat_o      write data
// -----------------------------------------------------------------------------
module cacc_csb_req_decode
   import nvdla_cacc_csb_pkg::*;
#(
   parameter logic [11:0] BLK_ADDR_HI = 12'h009
) (
   input  logic [PD_W-1:0] req_pd_i,
   output logic            is_write_o,
   output logic            nposted_o,
   output logic            hit_o,
   output logic            fwd_o,
   output logic            err_o,
   output logic [11:0]     offset_o,
   output logic [31:0]     wdat_o
);

   logic [21:0] addr;
   logic        unused_fields;

   assign addr       = req_pd_i[ADDR_MSB:ADDR_LSB];
   assign wdat_o     = req_pd_i[WDAT_MSB:WDAT_LSB];
   assign is_write_o = req_pd_i[WRITE_BIT];
   assign nposted_o  = req_pd_i[NPOSTED_BIT];
   assign hit_o      = (addr[21:10] == BLK_ADDR_HI);
   // Word address to byte offset: always 4-aligned.
   assign offset_o   = {addr[9:0], 2'b00};

   // Privilege, byte enables and level carry no meaning here.
   assign unused_fields = ^req_pd_i[IGN_MSB:IGN_LSB];

`ifdef CACC_CSB_ADDR_ERR_EN
   logic unmapped;
   assign unmapped = hit_o && ((offset_o < MAP_LO) || (offset_o > MAP_HI));
   assign fwd_o    = hit_o && !unmapped;
   assign err_o    = !hit_o || unmapped;
`else
   assign fwd_o    = hit_o;
   assign err_o    = 1'b0;
`endif

endmodule

// File: rtl/cacc_csb_reg_master.sv
// -----------------------------------------------------------------------------
// cacc_csb_reg_master
// CSB-side initiator for the CACC register group. One request is in flight at
// a time: IDLE (accept) -> ACCESS (register port driven) -> RESP (response
// pulse), giving one request every 3 cycles.
// Build option: CACC_CSB_ADDR_ERR_EN enables unmapped-offset/miss error
// reporting (see cacc_csb_req_decode).
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn  clock, async active-low reset
//   csb2cacc_req_pvld/prdy/pd         request handshake and packet
//   cacc2csb_resp_valid/pd            response pulse and packet (no backpressure)
//   reg_offset/reg_wr_en/reg_wr_data  registered register-file access port
//   reg_rd_data                       combinational read data from register file
// -----------------------------------------------------------------------------
module cacc_csb_reg_master
   import nvdla_cacc_csb_pkg::*;
#(
   parameter logic [11:0] BLK_ADDR_HI = 12'h009
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rstn,
   input  logic              csb2cacc_req_pvld,
   output logic              csb2cacc_req_prdy,
   input  logic [PD_W-1:0]   csb2cacc_req_pd,
   output logic              cacc2csb_resp_valid,
   output logic [RESP_W-1:0] cacc2csb_resp_pd,
   output logic [11:0]       reg_offset,
   output logic              reg_wr_en,
   output logic [31:0]       reg_wr_data,
   input  logic [31:0]       reg_rd_data
);

   state_e             state_q, state_d;
   req_info_t          req_q, req_d;
   logic [11:0]        reg_offset_q, reg_offset_d;
   logic               reg_wr_en_q, reg_wr_en_d;
   logic [31:0]        reg_wr_data_q, reg_wr_data_d;
   logic               resp_valid_q, resp_valid_d;
   logic [RESP_W-1:0]  resp_pd_q, resp_pd_d;

   logic        dec_is_write, dec_nposted, dec_hit, dec_fwd, dec_err;
   logic [11:0] dec_offset;
   logic [31:0] dec_wdat;

   // Decode the incoming packet so the register port is already registered
   // and valid during the ACCESS cycle.
   cacc_csb_req_decode #(
      .BLK_ADDR_HI (BLK_ADDR_HI)
   ) u_decode (
      .req_pd_i   (csb2cacc_req_pd),
      .is_write_o (dec_is_write),
      .nposted_o  (dec_nposted),
      .hit_o      (dec_hit),
      .fwd_o      (dec_fwd),
      .err_o      (dec_err),
      .offset_o   (dec_offset),
      .wdat_o     (dec_wdat)
   );

   assign csb2cacc_req_prdy = (state_q == IDLE);

   // NOTE: every variable assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      reg_offset_d  = reg_offset_q;
      reg_wr_data_d = reg_wr_data_q;
      reg_wr_en_d   = 1'b0;
      resp_valid_d  = 1'b0;
      resp_pd_d     = resp_pd_q;

      unique case (state_q)
         IDLE: begin
            if (csb2cacc_req_pvld) begin
               state_d        = ACCESS;
               req_d.is_write = dec_is_write;
               req_d.nposted  = dec_nposted;
               req_d.fwd      = dec_fwd;
               req_d.err      = dec_err;
               reg_offset_d   = dec_offset;
               reg_wr_en_d    = dec_is_write && dec_fwd;
               if (dec_is_write && dec_hit) begin
                  reg_wr_data_d = dec_wdat;
               end
            end
         end
         ACCESS: begin
            state_d = RESP;
            // Reads and non-posted writes answer; reg_rd_data is captured here.
            if (!req_q.is_write || req_q.nposted) begin
               resp_valid_d = 1'b1;
               resp_pd_d    = pack_resp(req_q.is_write ? RESP_WRACK : RESP_READ,
                                        req_q.err,
                                        (!req_q.is_write && req_q.fwd) ? reg_rd_data : 32'h0);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q       <= IDLE;
         req_q         <= '0;
         reg_offset_q  <= '0;
         reg_wr_en_q   <= 1'b0;
         reg_wr_data_q <= '0;
         resp_valid_q  <= 1'b0;
         resp_pd_q     <= '0;
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         reg_offset_q  <= reg_offset_d;
         reg_wr_en_q   <= reg_wr_en_d;
         reg_wr_data_q <= reg_wr_data_d;
         resp_valid_q  <= resp_valid_d;
         resp_pd_q     <= resp_pd_d;
      end
   end

   assign reg_offset          = reg_offset_q;
   assign reg_wr_en           = reg_wr_en_q;
   assign reg_wr_data         = reg_wr_data_q;
   assign cacc2csb_resp_valid = resp_valid_q;
   assign cacc2csb_resp_pd    = resp_pd_q;

endmodule
